// File: rtl/irq_pkg.sv
// -----------------------------------------------------------------------------
// irq_pkg
// Shared types and constants for the interrupt arbiter controller.
//   irq_state_e : handshake FSM states (IDLE -> REQ -> SVC -> IDLE)
//   IRQ_MAX_SRC : largest supported number of interrupt sources
// -----------------------------------------------------------------------------
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } irq_state_e;

    localparam int IRQ_MAX_SRC = 32;

endpackage : irq_pkg

// File: rtl/irq_src_detect.sv
// -----------------------------------------------------------------------------
// irq_src_detect
// Two-flop falling-edge detector for one interrupt line that is already
// synchronous to clk.
// Ports:
//   clk    : system clock
//   rst_n  : synchronous active-low reset
//   irq_i  : interrupt line
//   fall_o : one-cycle pulse after the line is first sampled low
// Both stages reset to 0, so a line that idles high after reset looks like a
// rising edge (ignored) instead of a false falling edge.
// -----------------------------------------------------------------------------
module irq_src_detect
    import irq_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic irq_i,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;

    // Sample the line into a two-stage history shift register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= irq_i;
            s2_q <= s1_q;
        end
    end

    // Previous sample high and newest sample low marks a falling edge.
    assign fall_o = ~s1_q & s2_q;

endmodule : irq_src_detect

// File: rtl/irq_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// irq_arbiter_ctrl
// Latches falling edges on NUM_SRC interrupt lines as pending flags and hands
// one enabled pending source at a time to the CPU-side handler through a
// valid/ack handshake, then waits for an end-of-interrupt pulse before the
// next grant.
// Parameters:
//   NUM_SRC     : number of sources (2..32)
//   ID_W        : width of the source ID
//   ROUND_ROBIN : 0 = lowest index wins, 1 = rotating priority
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   irq_in      : interrupt lines, falling edge requests service
//   irq_en      : per-source eligibility mask
//   irq_valid   : grant presented to the handler
//   irq_id      : granted source ID (holds its last value when not valid)
//   irq_ack     : handler accepts the grant
//   irq_eoi     : single-cycle end-of-interrupt pulse
//   in_service  : grant accepted, awaiting EOI
//   irq_pend    : pending flags
// -----------------------------------------------------------------------------
module irq_arbiter_ctrl
    import irq_pkg::*;
#(
    parameter int NUM_SRC     = 8,
    parameter int ID_W        = $clog2(NUM_SRC),
    parameter int ROUND_ROBIN = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic [NUM_SRC-1:0] irq_en,
    output logic               irq_valid,
    output logic [ID_W-1:0]    irq_id,
    input  logic               irq_ack,
    input  logic               irq_eoi,
    output logic               in_service,
    output logic [NUM_SRC-1:0] irq_pend
);

    generate
        if ((NUM_SRC < 2) || (NUM_SRC > IRQ_MAX_SRC)) begin : g_bad_num_src
            $error("irq_arbiter_ctrl: NUM_SRC out of range");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Source selection: first eligible index starting at 'start'. In fixed
    // priority mode the scan always starts at 0 and 'start' is not used.
    // -------------------------------------------------------------------------
    function automatic logic [ID_W-1:0] select_src(
        input logic [NUM_SRC-1:0] elig,
        input logic [ID_W-1:0]    start
    );
        logic            found;
        logic [ID_W-1:0] sel;
        int              idx;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (ROUND_ROBIN != 0) begin
                idx = (int'(start) + k) % NUM_SRC;
            end else begin
                idx = k;
            end
            if (!found && elig[idx]) begin
                found = 1'b1;
                sel   = ID_W'(idx);
            end else begin
                found = found;
            end
        end
        return sel;
    endfunction

    // -------------------------------------------------------------------------
    // Per-source falling-edge detectors
    // -------------------------------------------------------------------------
    logic [NUM_SRC-1:0] fall_s;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_det
            irq_src_detect u_det (
                .clk    (clk),
                .rst_n  (rst_n),
                .irq_i  (irq_in[gi]),
                .fall_o (fall_s[gi])
            );
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    irq_state_e         state_q,   state_d;
    logic               valid_q,   valid_d;
    logic [ID_W-1:0]    id_q,      id_d;
    logic               insvc_q,   insvc_d;
    logic [ID_W-1:0]    ptr_q,     ptr_d;
    logic [NUM_SRC-1:0] pend_q,    pend_d;

    logic               hs_s;
    logic [NUM_SRC-1:0] elig_s;
    logic [NUM_SRC-1:0] clr_s;
    logic [ID_W-1:0]    sel_s;

    // Disabled sources stay pending but are hidden from the arbiter.
    assign elig_s = pend_q & irq_en;
    assign sel_s  = select_src(elig_s, ptr_q);

    // Handshake FSM: next state, grant registers and rotation pointer.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        id_d    = id_q;
        insvc_d = insvc_q;
        ptr_d   = ptr_q;
        hs_s    = 1'b0;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (elig_s != '0) begin
                    id_d    = sel_s;
                    valid_d = 1'b1;
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                // No retraction: the grant stays up until acknowledged.
                valid_d = 1'b1;
                if (irq_ack) begin
                    hs_s    = 1'b1;
                    valid_d = 1'b0;
                    insvc_d = 1'b1;
                    state_d = SVC;
                    if (id_q == ID_W'(NUM_SRC - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = id_q + ID_W'(1);
                    end
                end else begin
                    state_d = REQ;
                end
            end
            SVC: begin
                if (irq_eoi) begin
                    insvc_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = SVC;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                insvc_d = 1'b0;
            end
        endcase
    end

    // Pending flags: a new edge wins over the handshake clear in the same cycle.
    always_comb begin
        if (hs_s) begin
            clr_s = {{(NUM_SRC-1){1'b0}}, 1'b1} << id_q;
        end else begin
            clr_s = '0;
        end
        pend_d = (pend_q & ~clr_s) | fall_s;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            id_q    <= '0;
            insvc_q <= 1'b0;
            ptr_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            insvc_q <= insvc_d;
            ptr_q   <= ptr_d;
            pend_q  <= pend_d;
        end
    end

    assign irq_valid  = valid_q;
    assign irq_id     = id_q;
    assign in_service = insvc_q;
    assign irq_pend   = pend_q;

endmodule : irq_arbiter_ctrl

// File: tb/tb_irq_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_arbiter_ctrl
// Directed bench: one fixed-priority instance and one rotating-priority
// instance share clock and reset. Outputs are sampled 1 ns after the rising
// edge; inputs are changed at the same point so they are taken on the next edge.
// -----------------------------------------------------------------------------
module tb_irq_arbiter_ctrl;

    logic       clk;
    logic       rst_n;

    logic [7:0] fp_in, fp_en, fp_pend;
    logic       fp_valid, fp_ack, fp_eoi, fp_insvc;
    logic [2:0] fp_id;

    logic [7:0] rr_in, rr_en, rr_pend;
    logic       rr_valid, rr_ack, rr_eoi, rr_insvc;
    logic [2:0] rr_id;

    int n_checks = 0;
    int n_err    = 0;

    irq_arbiter_ctrl #(.NUM_SRC(8), .ROUND_ROBIN(0)) dut_fp (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_in     (fp_in),
        .irq_en     (fp_en),
        .irq_valid  (fp_valid),
        .irq_id     (fp_id),
        .irq_ack    (fp_ack),
        .irq_eoi    (fp_eoi),
        .in_service (fp_insvc),
        .irq_pend   (fp_pend)
    );

    irq_arbiter_ctrl #(.NUM_SRC(8), .ROUND_ROBIN(1)) dut_rr (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_in     (rr_in),
        .irq_en     (rr_en),
        .irq_valid  (rr_valid),
        .irq_id     (rr_id),
        .irq_ack    (rr_ack),
        .irq_eoi    (rr_eoi),
        .in_service (rr_insvc),
        .irq_pend   (rr_pend)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop if the sequence never completes.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int exp_id;

        rst_n  = 1'b0;
        fp_in  = 8'hFF; fp_en = 8'hFF; fp_ack = 1'b0; fp_eoi = 1'b0;
        rr_in  = 8'hFF; rr_en = 8'hFF; rr_ack = 1'b0; rr_eoi = 1'b0;

        // ---- 1: reset state, idle-high lines give no false edge ----
        tick(); tick();
        chk("rst_valid",  32'(fp_valid), 32'h0);
        chk("rst_id",     32'(fp_id),    32'h0);
        chk("rst_insvc",  32'(fp_insvc), 32'h0);
        chk("rst_pend",   32'(fp_pend),  32'h0);
        chk("rst_rr_pend", 32'(rr_pend), 32'h0);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle_pend",  32'(fp_pend),  32'h0);
            chk("idle_valid", 32'(fp_valid), 32'h0);
        end

        // ack/eoi while idle are ignored
        fp_ack = 1'b1; fp_eoi = 1'b1;
        tick();
        chk("ign_ack_insvc", 32'(fp_insvc), 32'h0);
        chk("ign_ack_valid", 32'(fp_valid), 32'h0);
        fp_ack = 1'b0; fp_eoi = 1'b0;

        // ---- 2: single source 3, latency and full handshake ----
        fp_in[3] = 1'b0;
        tick();
        chk("t2_pend_k1", 32'(fp_pend), 32'h00);
        tick();
        chk("t2_pend_k2",  32'(fp_pend),  32'h08);
        chk("t2_valid_k2", 32'(fp_valid), 32'h0);
        tick();
        chk("t2_valid_k3", 32'(fp_valid), 32'h1);
        chk("t2_id_k3",    32'(fp_id),    32'h3);
        fp_eoi = 1'b1;                        // eoi in REQ must be ignored
        tick();
        fp_eoi = 1'b0;
        chk("t2_valid_hold", 32'(fp_valid), 32'h1);
        chk("t2_insvc_hold", 32'(fp_insvc), 32'h0);
        fp_ack = 1'b1;
        tick();
        fp_ack = 1'b0;
        chk("t2_pend_ack",  32'(fp_pend),  32'h00);
        chk("t2_valid_ack", 32'(fp_valid), 32'h0);
        chk("t2_insvc_ack", 32'(fp_insvc), 32'h1);
        fp_in[3] = 1'b1;
        tick(); tick();
        chk("t2_insvc_wait", 32'(fp_insvc), 32'h1);
        chk("t2_id_retain",  32'(fp_id),    32'h3);
        fp_eoi = 1'b1;
        tick();
        fp_eoi = 1'b0;
        chk("t2_insvc_eoi", 32'(fp_insvc), 32'h0);

        // ---- 3: fixed priority, sources 5 and 2 together ----
        fp_in[5] = 1'b0; fp_in[2] = 1'b0;
        tick(); tick();
        chk("t3_pend", 32'(fp_pend), 32'h24);
        tick();
        chk("t3_valid1", 32'(fp_valid), 32'h1);
        chk("t3_id1",    32'(fp_id),    32'h2);
        fp_ack = 1'b1;
        tick();
        fp_ack = 1'b0;
        chk("t3_pend_ack1", 32'(fp_pend), 32'h20);
        fp_in[5] = 1'b1; fp_in[2] = 1'b1;
        fp_eoi = 1'b1;
        tick();
        fp_eoi = 1'b0;
        chk("t3_valid_eoi", 32'(fp_valid), 32'h0);
        tick();
        chk("t3_valid2", 32'(fp_valid), 32'h1);
        chk("t3_id2",    32'(fp_id),    32'h5);
        fp_ack = 1'b1;
        tick();
        fp_ack = 1'b0;
        chk("t3_pend_ack2", 32'(fp_pend), 32'h00);
        fp_eoi = 1'b1;
        tick();
        fp_eoi = 1'b0;

        // ---- 5: disabled source stays pending, grant once enabled ----
        fp_en = 8'hEF;
        fp_in[4] = 1'b0;
        tick(); tick();
        chk("t5_pend", 32'(fp_pend), 32'h10);
        tick(); tick();
        chk("t5_masked_valid", 32'(fp_valid), 32'h0);
        fp_en = 8'hFF;
        tick();
        chk("t5_valid", 32'(fp_valid), 32'h1);
        chk("t5_id",    32'(fp_id),    32'h4);
        fp_ack = 1'b1;
        tick();
        fp_ack = 1'b0;
        fp_in[4] = 1'b1;
        fp_eoi = 1'b1;
        tick();
        fp_eoi = 1'b0;
        chk("t5_pend_done",  32'(fp_pend),  32'h00);
        chk("t5_insvc_done", 32'(fp_insvc), 32'h0);

        // ---- 4: rotating priority, 0,1,2 re-armed after each grant ----
        rr_in = 8'hF8;
        for (int g = 0; g < 9; g++) begin
            exp_id = g % 3;
            for (int c = 0; c < 12 && !rr_valid; c++) begin
                tick();
            end
            chk("rr_valid", 32'(rr_valid), 32'h1);
            chk("rr_id",    32'(rr_id),    32'(exp_id));
            rr_ack = 1'b1;
            tick();
            rr_ack = 1'b0;
            chk("rr_insvc", 32'(rr_insvc), 32'h1);
            rr_in[exp_id] = 1'b1;
            tick(); tick();
            rr_in[exp_id] = 1'b0;
            tick(); tick();
            chk("rr_pend_rearm", 32'(rr_pend), 32'h07);
            rr_eoi = 1'b1;
            tick();
            rr_eoi = 1'b0;
        end

        // ---- 6: edge coincident with ack keeps pend, then reset in REQ ----
        fp_in[1] = 1'b0;
        tick(); tick(); tick();
        chk("t6_valid1", 32'(fp_valid), 32'h1);
        chk("t6_id1",    32'(fp_id),    32'h1);
        fp_in[1] = 1'b1;
        tick(); tick();
        fp_in[1] = 1'b0;
        tick();
        fp_ack = 1'b1;
        tick();
        fp_ack = 1'b0;
        chk("t6_pend_setwins", 32'(fp_pend),  32'h02);
        chk("t6_insvc",        32'(fp_insvc), 32'h1);
        chk("t6_valid_ack",    32'(fp_valid), 32'h0);
        fp_eoi = 1'b1;
        tick();
        fp_eoi = 1'b0;
        tick();
        chk("t6_valid2", 32'(fp_valid), 32'h1);
        chk("t6_id2",    32'(fp_id),    32'h1);
        rst_n = 1'b0;
        tick();
        chk("t6_rst_valid", 32'(fp_valid), 32'h0);
        chk("t6_rst_pend",  32'(fp_pend),  32'h00);
        chk("t6_rst_insvc", 32'(fp_insvc), 32'h0);
        chk("t6_rst_id",    32'(fp_id),    32'h0);
        chk("t6_rst_rr_pend", 32'(rr_pend), 32'h00);
        rst_n = 1'b1;
        fp_in = 8'hFF;
        tick(); tick(); tick();
        chk("t6_post_pend",  32'(fp_pend),  32'h00);
        chk("t6_post_valid", 32'(fp_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_irq_arbiter_ctrl
